// File: rtl/skid_buffer_pkg.sv
// Shared types for the write-side skid buffer.
// Defines the FSM state enum, depth and fill helper.
package skid_buffer_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_BUSY,
    SKID_FULL
  } skid_state_e;

  localparam int SKID_DEPTH = 2;

  function automatic logic [1:0] skid_fill(
    input skid_state_e s
  );
    logic [1:0] f;
    f = 2'd0;
    unique case (s)
      SKID_EMPTY: f = 2'd0;
      SKID_BUSY:  f = 2'd1;
      SKID_FULL:  f = 2'(SKID_DEPTH);
      default:    f = 2'd0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/skid_data_reg.sv
// Enable-loaded data register, no reset.
// Ports: clk, en (load), d (next word), q (held word).
module skid_data_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (en) q <= d;
  end

endmodule

// File: rtl/skid_buffer_ingress.sv
// Write-side register slice feeding a FIFO push port.
// Ports: clk, rst (async high), in_valid/in_ready/in_data
// upstream, out_valid/out_ready/out_data downstream,
// fill_level = words held (0..2).
// Option: SKID_BUFFER_INGRESS_BYPASS_EN gives a
// zero-latency path while EMPTY and out_ready=1.
module skid_buffer_ingress
  import skid_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            fill_level
);

  skid_state_e state_q, state_d;
  logic in_ready_q, out_valid_q;
  logic [1:0] fill_q;
  logic byp, in_fire, out_fire;
  logic main_en, skid_en;
  logic [DATA_WIDTH-1:0] main_q, skid_q, main_d;

`ifdef SKID_BUFFER_INGRESS_BYPASS_EN
  // Empty and downstream ready: the word flows
  // straight through and nothing is stored.
  assign byp = (state_q == SKID_EMPTY) & out_ready;
`else
  assign byp = 1'b0;
`endif

  assign in_ready   = in_ready_q;
  assign out_valid  = byp ? in_valid : out_valid_q;
  assign out_data   = byp ? in_data : main_q;
  assign fill_level = fill_q;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    unique case (state_q)
      SKID_EMPTY: begin
        if (in_fire && !byp) begin
          state_d = SKID_BUSY;
          main_en = 1'b1;
        end
      end
      SKID_BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          state_d = SKID_FULL;
          skid_en = 1'b1;
        end else if (out_fire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_fire) begin
          state_d = SKID_BUSY;
          main_en = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // Main refills from the skid only when draining FULL.
  assign main_d = (state_q == SKID_FULL) ? skid_q
                                         : in_data;

  // Outputs are decoded from the next state so they
  // leave the block as plain flop outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SKID_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      fill_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != SKID_FULL);
      out_valid_q <= (state_d != SKID_EMPTY);
      fill_q      <= skid_fill(state_d);
    end
  end

  skid_data_reg #(.DATA_WIDTH(DATA_WIDTH)) u_main (
    .clk (clk),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  skid_data_reg #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk (clk),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_skid_buffer_ingress.sv
// Self-checking bench for skid_buffer_ingress.
// Directed table, corner sequences, random scoreboard.
module tb_skid_buffer_ingress;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  fill_level;

  int n_chk;
  int n_fail;

  skid_buffer_ingress #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fill_level (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [31:0] din;
    logic        ov;
    logic        chk_d;
    logic [31:0] od;
    logic        ir;
    logic [1:0]  fl;
  } vec_t;

  vec_t tbl [6];
  logic [31:0] q [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        ir0;
    logic        stalled;
    logic [31:0] held;
    logic        inf, outf;

    n_chk  = 0;
    n_fail = 0;

    // backpressure: A1, A2 fill, A3 waits, then drain
    tbl[0] = '{1'b1, 1'b0, 32'hA1,
               1'b1, 1'b1, 32'hA1, 1'b1, 2'd1};
    tbl[1] = '{1'b1, 1'b0, 32'hA2,
               1'b1, 1'b1, 32'hA1, 1'b0, 2'd2};
    tbl[2] = '{1'b1, 1'b0, 32'hA3,
               1'b1, 1'b1, 32'hA1, 1'b0, 2'd2};
    tbl[3] = '{1'b1, 1'b1, 32'hA3,
               1'b1, 1'b1, 32'hA2, 1'b1, 2'd1};
    tbl[4] = '{1'b1, 1'b1, 32'hA3,
               1'b1, 1'b1, 32'hA3, 1'b1, 2'd1};
    tbl[5] = '{1'b0, 1'b1, 32'h0,
               1'b0, 1'b0, 32'h0, 1'b1, 2'd0};

    // reset with in_valid asserted
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 32'hFF;
    repeat (2) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rel_out_valid", 32'(out_valid), 32'd0);
    chk("rel_fill", 32'(fill_level), 32'd0);

    // streaming
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = 32'(i);
      tick();
      chk("strm_valid", 32'(out_valid), 32'd1);
      chk("strm_data", out_data, 32'(i));
      chk("strm_fill", 32'(fill_level), 32'd1);
      chk("strm_ready", 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    chk("strm_end", 32'(out_valid), 32'd0);

    // table
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      in_data   = tbl[i].din;
      tick();
      chk($sformatf("tbl%0d_ov", i),
          32'(out_valid), 32'(tbl[i].ov));
      if (tbl[i].chk_d)
        chk($sformatf("tbl%0d_od", i),
            out_data, tbl[i].od);
      chk($sformatf("tbl%0d_ir", i),
          32'(in_ready), 32'(tbl[i].ir));
      chk($sformatf("tbl%0d_fl", i),
          32'(fill_level), 32'(tbl[i].fl));
    end

    // mid-transfer reset while FULL
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 32'h11;
    tick();
    @(negedge clk);
    in_data = 32'h22;
    tick();
    chk("mr_full", 32'(fill_level), 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("mr_ov", 32'(out_valid), 32'd0);
    chk("mr_fill", 32'(fill_level), 32'd0);
    chk("mr_ir", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h33;
    tick();
    chk("mr_first", out_data, 32'h33);
    chk("mr_fl1", 32'(fill_level), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("mr_drain", 32'(out_valid), 32'd0);

    // random stall scoreboard
    q.delete();
    stalled = 1'b0;
    held    = 32'h0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      #1;
      ir0       = in_ready;
      out_ready = ~out_ready;
      #1;
      chk("ready_comb", 32'(in_ready), 32'(ir0));
      out_ready = ~out_ready;
      #1;
      if (stalled) chk("stable", out_data, held);
      inf  = in_valid & in_ready;
      outf = out_valid & out_ready;
      if (inf) q.push_back(in_data);
      if (outf) begin
        chk("pop_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0)
          chk("order", out_data, q.pop_front());
      end
      stalled = out_valid & ~out_ready;
      held    = out_data;
      tick();
      chk("rnd_fill", 32'(fill_level), 32'(q.size()));
    end

    // drain to EMPTY
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("drained", 32'(fill_level), 32'd0);

    // bypass behaviour
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h5A;
    #1;
`ifdef SKID_BUFFER_INGRESS_BYPASS_EN
    chk("byp_ov", 32'(out_valid), 32'd1);
    chk("byp_od", out_data, 32'h5A);
    chk("byp_fl", 32'(fill_level), 32'd0);
    tick();
    chk("byp_fl_after", 32'(fill_level), 32'd0);
`else
    chk("nobyp_ov", 32'(out_valid), 32'd0);
    tick();
    chk("nobyp_ov1", 32'(out_valid), 32'd1);
    chk("nobyp_od1", out_data, 32'h5A);
    chk("nobyp_fl1", 32'(fill_level), 32'd1);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
